// File: rtl/nec_ir_tx_pkg.sv
// nec_ir_pkg: NEC unit counts, frame FSM states, payload packing and miniCar command codes.
// NEC_EXT_ADDR_EN selects a 16-bit address (extended NEC) instead of addr/~addr.
package nec_ir_pkg;

`ifdef NEC_EXT_ADDR_EN
  localparam int ADDR_W = 16;
`else
  localparam int ADDR_W = 8;
`endif

  localparam logic [4:0] LEAD_MARK_U  = 5'd16;
  localparam logic [4:0] LEAD_SPACE_U = 5'd8;
  localparam logic [4:0] RPT_SPACE_U  = 5'd4;
  localparam logic [4:0] ONE_SPACE_U  = 5'd3;
  localparam logic [4:0] ZERO_SPACE_U = 5'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_RPT_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_GUARD
  } nec_state_t;

  // miniCar remote codes, shared with the frame decoder
  localparam logic [7:0] CMD_FWD_FAST = 8'h45;
  localparam logic [7:0] CMD_STOP     = 8'h47;
  localparam logic [7:0] CMD_LEFT     = 8'h07;
  localparam logic [7:0] CMD_RIGHT    = 8'h09;

  // Word is transmitted LSB first, so the address byte goes out first.
  function automatic logic [31:0] nec_payload(input logic [ADDR_W-1:0] addr,
                                              input logic [7:0]        cmd);
`ifdef NEC_EXT_ADDR_EN
    return {~cmd, cmd, addr};
`else
    return {~cmd, cmd, ~addr, addr};
`endif
  endfunction

endpackage

// File: rtl/nec_ir_tx_if.sv
// nec_ir_tx_if: request handshake and IR outputs of the NEC transmitter.
// Address width follows NEC_EXT_ADDR_EN through nec_ir_pkg::ADDR_W.
interface nec_ir_tx_if;
  import nec_ir_pkg::*;

  logic              tx_start;
  logic              tx_repeat;
  logic [ADDR_W-1:0] tx_addr;
  logic [7:0]        tx_cmd;
  logic              tx_ready;
  logic              tx_busy;
  logic              tx_done;
  logic              ir_env;
  logic              ir_out;

  modport master (
    output tx_start, tx_repeat, tx_addr, tx_cmd,
    input  tx_ready, tx_busy, tx_done, ir_env, ir_out
  );

  modport slave (
    input  tx_start, tx_repeat, tx_addr, tx_cmd,
    output tx_ready, tx_busy, tx_done, ir_env, ir_out
  );
endinterface

// File: rtl/nec_ir_tx_carrier.sv
// nec_carrier_gen: ~38 kHz carrier phase counter; idles at phase 0 with the carrier high,
// so every mark begins on a high half-period. o_carrier_nxt is the value after this edge.
module nec_carrier_gen
  import nec_ir_pkg::*;
#(
  parameter int CARRIER_HALF = 1316
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_restart,
  output logic o_carrier_nxt
);
  localparam int PW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  logic [PW-1:0] r_phase;
  logic          r_carrier;
  logic          w_wrap;

  assign w_wrap = (r_phase == PW'(CARRIER_HALF - 1));

  always_comb begin
    o_carrier_nxt = 1'b1;
    if (i_en && !i_restart) o_carrier_nxt = w_wrap ? ~r_carrier : r_carrier;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_phase   <= '0;
      r_carrier <= 1'b1;
    end else if (!i_en || i_restart) begin
      r_phase   <= '0;
      r_carrier <= 1'b1;
    end else begin
      r_phase   <= w_wrap ? '0 : r_phase + 1'b1;
      r_carrier <= o_carrier_nxt;
    end
  end
endmodule

// File: rtl/nec_ir_tx.sv
// nec_ir_tx: NEC IR frame transmitter (data or repeat frame) with registered envelope/carrier outputs.
// Build option NEC_EXT_ADDR_EN: 16-bit address sent verbatim instead of addr/~addr.
module nec_ir_tx
  import nec_ir_pkg::*;
#(
  parameter int UNIT_CYC     = 56250,
  parameter int CARRIER_HALF = 1316,
  parameter int FRAME_UNITS  = 192,
  parameter bit OUT_INV      = 1'b0
) (
  input  logic         clk_in,
  input  logic         rst_n,
  nec_ir_tx_if.slave   bus
);
  localparam int UW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam int FW = (FRAME_UNITS > 1) ? $clog2(FRAME_UNITS) : 1;

  nec_state_t    r_state;
  logic [UW-1:0] r_div;
  logic [FW-1:0] r_frame;
  logic [4:0]    r_ucnt;
  logic [4:0]    r_bit;
  logic [31:0]   r_shift;
  logic          r_rpt, r_env, r_out, r_ready, r_busy, r_done;

  logic          w_accept, w_tick, w_bit_done, w_carrier_nxt;
  logic [4:0]    w_space_u;

  assign w_accept   = r_ready & bus.tx_start;
  assign w_tick     = (r_div == UW'(UNIT_CYC - 1));
  assign w_space_u  = r_shift[0] ? ONE_SPACE_U : ZERO_SPACE_U;
  assign w_bit_done = (r_state == S_BIT_SPACE) && w_tick && (r_ucnt == w_space_u - 5'd1);

  nec_carrier_gen #(.CARRIER_HALF(CARRIER_HALF)) u_carrier (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .i_en         (r_env),
    .i_restart    (w_accept),
    .o_carrier_nxt(w_carrier_nxt)
  );

  // Transition edges set r_out directly so ir_out stays aligned with the registered envelope.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_frame <= '0;
      r_ucnt  <= '0;
      r_bit   <= '0;
      r_rpt   <= 1'b0;
      r_env   <= 1'b0;
      r_out   <= OUT_INV;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_out  <= (r_env & w_carrier_nxt) ^ OUT_INV;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          r_state <= S_LEAD_MARK;
          r_rpt   <= bus.tx_repeat;
          r_div   <= '0;
          r_frame <= '0;
          r_ucnt  <= '0;
          r_bit   <= '0;
          r_env   <= 1'b1;
          r_out   <= ~OUT_INV;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
        end
      end else begin
        r_div <= w_tick ? '0 : r_div + 1'b1;
        if (w_tick) begin
          r_frame <= r_frame + 1'b1;
          r_ucnt  <= r_ucnt + 5'd1;
          case (r_state)
            S_LEAD_MARK:
              if (r_ucnt == LEAD_MARK_U - 5'd1) begin
                r_state <= r_rpt ? S_RPT_SPACE : S_LEAD_SPACE;
                r_ucnt  <= '0;
                r_env   <= 1'b0;
                r_out   <= OUT_INV;
              end
            S_LEAD_SPACE:
              if (r_ucnt == LEAD_SPACE_U - 5'd1) begin
                r_state <= S_BIT_MARK;
                r_ucnt  <= '0;
                r_env   <= 1'b1;
                r_out   <= ~OUT_INV;
              end
            S_RPT_SPACE:
              if (r_ucnt == RPT_SPACE_U - 5'd1) begin
                r_state <= S_STOP_MARK;
                r_ucnt  <= '0;
                r_env   <= 1'b1;
                r_out   <= ~OUT_INV;
              end
            S_BIT_MARK: begin
              r_state <= S_BIT_SPACE;
              r_ucnt  <= '0;
              r_env   <= 1'b0;
              r_out   <= OUT_INV;
            end
            S_BIT_SPACE:
              if (w_bit_done) begin
                r_state <= (r_bit == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
                r_bit   <= r_bit + 5'd1;
                r_ucnt  <= '0;
                r_env   <= 1'b1;
                r_out   <= ~OUT_INV;
              end
            S_STOP_MARK: begin
              r_state <= S_GUARD;
              r_ucnt  <= '0;
              r_env   <= 1'b0;
              r_out   <= OUT_INV;
            end
            S_GUARD:
              if (r_frame == FW'(FRAME_UNITS - 1)) begin
                r_state <= S_IDLE;
                r_ready <= 1'b1;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  // Payload is pure data: loaded at acceptance, shifted as each bit space completes.
  always_ff @(posedge clk_in) begin
    if (w_accept)        r_shift <= nec_payload(bus.tx_addr, bus.tx_cmd);
    else if (w_bit_done) r_shift <= {1'b0, r_shift[31:1]};
  end

  assign bus.tx_ready = r_ready;
  assign bus.tx_busy  = r_busy;
  assign bus.tx_done  = r_done;
  assign bus.ir_env   = r_env;
  assign bus.ir_out   = r_out;
endmodule

// File: tb/tb_nec_ir_tx.sv
// Scoreboard bench for nec_ir_tx: expected envelope runs and tx_done cycles are queued at
// stimulus time and consumed by a monitor that watches ir_env, ir_out and tx_done.
`timescale 1ns/1ps
module tb_nec_ir_tx;
  import nec_ir_pkg::*;

  typedef struct {
    bit lvl;
    int len;
  } run_t;

`ifdef NEC_EXT_ADDR_EN
  localparam logic [ADDR_W-1:0] TADDR = 16'h1234;
  localparam logic [7:0] EB0 = 8'h34, EB1 = 8'h12, EB2 = 8'h45, EB3 = 8'hBA;
`else
  localparam logic [ADDR_W-1:0] TADDR = 8'h00;
  localparam logic [7:0] EB0 = 8'h00, EB1 = 8'hFF, EB2 = 8'h45, EB3 = 8'hBA;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_done = 0;
  run_t runq[$];
  int   doneq[$];
  bit   prev_env = 1'b0;
  bit   prev_ready = 1'b1;
  int   run_len = 0;
  int   mark_idx = 0;

  nec_ir_tx_if bus();

  nec_ir_tx #(
    .UNIT_CYC    (10),
    .CARRIER_HALF(2),
    .FRAME_UNITS (192),
    .OUT_INV     (1'b0)
  ) dut (
    .clk_in(clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_run(input bit lvl, input int len);
    run_t r;
    check("run_pending", int'(runq.size() > 0), 1);
    if (runq.size() > 0) begin
      r = runq.pop_front();
      check("run_level", int'(lvl), int'(r.lvl));
      check(lvl ? "mark_len" : "space_len", len, r.len);
    end
  endtask

  // Monitor: a low run that ends in a frame start (previous sample idle) is inter-frame gap.
  always @(negedge clk) begin
    if (!rst_n) begin
      runq.delete();
      doneq.delete();
      prev_env   = 1'b0;
      prev_ready = 1'b1;
      run_len    = 0;
      mark_idx   = 0;
    end else begin
      if (bus.ir_env !== prev_env) begin
        if (prev_env) pop_run(1'b1, run_len);
        else if (!prev_ready) pop_run(1'b0, run_len);
        run_len  = 1;
        mark_idx = 0;
      end else begin
        run_len++;
        mark_idx++;
      end
      check("ir_out", int'(bus.ir_out), int'(bus.ir_env && ((mark_idx % 4) < 2)));
      check("busy_vs_ready", int'(bus.tx_busy), int'(!bus.tx_ready));
      if (bus.tx_done) begin
        n_done++;
        check("tx_done_pending", int'(doneq.size() > 0), 1);
        if (doneq.size() > 0) check("tx_done_cycle", cyc, doneq.pop_front());
      end
      prev_env   = bus.ir_env;
      prev_ready = bus.tx_ready;
    end
  end

  task automatic push_run(input bit l, input int n);
    run_t r;
    r.lvl = l;
    r.len = n;
    runq.push_back(r);
  endtask

  task automatic expect_frame(input bit rpt, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
    logic [31:0] w;
    w = {b3, b2, b1, b0};
    push_run(1'b1, 160);
    if (rpt) begin
      push_run(1'b0, 40);
    end else begin
      push_run(1'b0, 80);
      for (int i = 0; i < 32; i++) begin
        push_run(1'b1, 10);
        push_run(1'b0, w[i] ? 30 : 10);
      end
    end
    push_run(1'b1, 10);
  endtask

  task automatic send(input bit rpt, input logic [ADDR_W-1:0] a, input logic [7:0] c,
                      output int acc);
    @(negedge clk);
    bus.tx_start  = 1'b1;
    bus.tx_repeat = rpt;
    bus.tx_addr   = a;
    bus.tx_cmd    = c;
    acc = cyc + 1;
    doneq.push_back(acc + 1920);
    @(negedge clk);
    bus.tx_start = 1'b0;
    check("ready_low_after_accept", int'(bus.tx_ready), 0);
    check("env_high_after_accept", int'(bus.ir_env), 1);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (doneq.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done_in_time"}, doneq.size(), 0);
    @(negedge clk);
    check({name, "_runs_consumed"}, runq.size(), 0);
    check({name, "_ready_after_done"}, int'(bus.tx_ready), 1);
  endtask

  initial begin
    int acc;
    int done_before;
    bus.tx_start  = 1'b0;
    bus.tx_repeat = 1'b0;
    bus.tx_addr   = '0;
    bus.tx_cmd    = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_ir_out", int'(bus.ir_out), 0);
    check("rst_ir_env", int'(bus.ir_env), 0);
    check("rst_ready", int'(bus.tx_ready), 1);
    check("rst_busy", int'(bus.tx_busy), 0);
    check("rst_done", int'(bus.tx_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ir_out", int'(bus.ir_out), 0);
    check("idle_ir_env", int'(bus.ir_env), 0);
    check("idle_ready", int'(bus.tx_ready), 1);
    check("idle_done", int'(bus.tx_done), 0);

    // Data frame
    expect_frame(1'b0, EB0, EB1, EB2, EB3);
    send(1'b0, TADDR, CMD_FWD_FAST, acc);
    wait_done("data");

    // Repeat frame
    expect_frame(1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    send(1'b1, TADDR, CMD_FWD_FAST, acc);
    wait_done("repeat");

    // Request while busy is dropped
    done_before = n_done;
    expect_frame(1'b0, EB0, EB1, EB2, EB3);
    send(1'b0, TADDR, CMD_FWD_FAST, acc);
    while (cyc < acc + 500) @(negedge clk);
    bus.tx_start = 1'b1;
    bus.tx_cmd   = CMD_STOP;
    @(negedge clk);
    bus.tx_start = 1'b0;
    wait_done("busy");
    repeat (300) @(negedge clk);
    check("busy_single_done", n_done - done_before, 1);
    check("busy_no_second_frame", int'(bus.ir_env), 0);

    // Reset mid-frame aborts without tx_done
    expect_frame(1'b0, EB0, EB1, EB2, EB3);
    send(1'b0, TADDR, CMD_FWD_FAST, acc);
    while (cyc < acc + 700) @(negedge clk);
    done_before = n_done;
    rst_n = 1'b0;
    #1;
    check("abort_ir_out", int'(bus.ir_out), 0);
    check("abort_ir_env", int'(bus.ir_env), 0);
    check("abort_ready", int'(bus.tx_ready), 1);
    check("abort_done", int'(bus.tx_done), 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2100) @(negedge clk);
    check("abort_no_done", n_done - done_before, 0);
    check("abort_idle_env", int'(bus.ir_env), 0);
    check("abort_idle_ready", int'(bus.tx_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/nec_ir_tx.md
Name: nec_ir_tx

Overview:
- NEC infrared frame transmitter for the miniCar remote link; the encoder counterpart of the car's IR frame decoder.
- Accepts an address/command byte pair, or a repeat request, from a control/test source.
- Emits the 38 kHz-modulated NEC waveform on ir_out to an IR LED driver, and the unmodulated envelope on ir_env for loopback into the on-board receiver.

Parameters:
- UNIT_CYC, 56250: clk_in cycles per 562.5 us NEC time unit (100 MHz clock).
- CARRIER_HALF, 1316: clk_in cycles per carrier half-period (~38 kHz).
- FRAME_UNITS, 192: units from frame start to next-frame ready (108 ms).
- OUT_INV, 0: 1 inverts ir_out, for an active-low LED driver.

Ports:
- clk_in, in, 1: system clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- tx_start, in, 1: transmit request, sampled each cycle.
- tx_repeat, in, 1: qualifies tx_start; 1 sends a repeat code, 0 sends a data frame.
- tx_addr, in, 8: address byte; 16 bits when NEC_EXT_ADDR_EN is defined.
- tx_cmd, in, 8: command byte (e.g. 8'h45, 8'h47).
- tx_ready, out, 1: idle; a request will be accepted.
- tx_busy, out, 1: frame or guard interval in progress; equals ~tx_ready.
- tx_done, out, 1: one-cycle pulse at end of guard interval.
- ir_env, out, 1: unmodulated envelope, 1 = mark.
- ir_out, out, 1: ir_env AND carrier, XOR OUT_INV.

Behaviour:
- Reset (async) values:
  - ir_env=0; ir_out=OUT_INV; tx_ready=1; tx_busy=0; tx_done=0.
  - State IDLE; all counters 0.
  - Reset asserted mid-frame aborts immediately; no partial completion and no tx_done.
- Handshake:
  - Request accepted on a clk_in edge where tx_start=1 and tx_ready=1.
  - tx_addr, tx_cmd and tx_repeat are latched on that edge.
  - tx_ready falls on the same edge.
  - tx_start while busy is ignored; nothing is queued.
- Output timing: all outputs registered; ir_env=1 starting the first cycle after the acceptance edge.
- Timing counters:
  - Unit divider counts 0..UNIT_CYC-1 and is cleared at acceptance; its wrap is unit_tick.
  - Frame unit counter counts unit_ticks from acceptance.
- States and durations (in units):
  - LEAD_MARK: 16, mark.
  - LEAD_SPACE: 8, space; data frame only.
  - RPT_SPACE: 4, space; repeat frame only.
  - BIT_MARK: 1, mark.
  - BIT_SPACE: 1 for bit 0, 3 for bit 1.
  - STOP_MARK: 1, mark.
  - GUARD: space until the frame counter reaches FRAME_UNITS.
- Transitions:
  - Data frame: IDLE -> LEAD_MARK -> LEAD_SPACE -> 32 x (BIT_MARK, BIT_SPACE) -> STOP_MARK -> GUARD -> IDLE.
  - Repeat frame: IDLE -> LEAD_MARK -> RPT_SPACE -> STOP_MARK -> GUARD -> IDLE.
- Payload: 32-bit shift register loaded {~cmd, cmd, ~addr, addr}, shifted LSB first; 5-bit bit counter; BIT_MARK follows BIT_SPACE until bit 31 completes.
- Guard end: tx_done=1 for one cycle, and tx_ready=1 on the same cycle.
  - The longest data frame (all ones) is 153 units, under 192, so GUARD is always entered.
- Carrier:
  - Phase counter counts 0..CARRIER_HALF-1, toggling the carrier on wrap.
  - Counter and carrier are forced to 0 and high at the first cycle of every mark, so each mark starts with a high carrier.
  - Held at 0 during spaces.
- Widths: counters are sized with $clog2 of their parameter; no wrap occurs within legal operation.

Optional Feature:
- Macro: NEC_EXT_ADDR_EN.
- Defined: tx_addr is 16 bits; payload is {~cmd, cmd, tx_addr[15:8], tx_addr[7:0]} (extended NEC).
- Undefined: tx_addr is 8 bits; second byte is ~tx_addr.
- Timing is identical in both cases.

Decomposition:
- Package nec_ir_pkg:
  - Unit counts: LEAD_MARK_U=16, LEAD_SPACE_U=8, RPT_SPACE_U=4, ONE_SPACE_U=3, ZERO_SPACE_U=1.
  - Frame FSM state enum.
  - miniCar command code constants (8'h45 straight fast, 8'h47 stop, 8'h07 left, 8'h09 right, ...), shared with the decoder.
- One sub-module: nec_carrier_gen, holding the phase counter and toggle, with enable and restart inputs.

Test Plan:
All scenarios use UNIT_CYC=10, CARRIER_HALF=2, OUT_INV=0.
1. Reset, then release -> ir_out=0, ir_env=0, tx_ready=1, tx_done=0.
2. Data frame:
   - Stimulus: tx_start one cycle, addr 8'h00, cmd 8'h45.
   - ir_env: 160 cycles high, then 80 low.
   - Then bytes 00, FF, 45, BA, LSB first, at 10/10 (bit 0) or 10/30 (bit 1) cycles mark/space.
   - Then a 10-cycle stop mark.
   - tx_done pulses 1920 cycles after acceptance.
3. Repeat frame:
   - Stimulus: tx_start with tx_repeat=1.
   - ir_env: 160 high, 40 low, 10 high, then low.
   - tx_done pulses at 1920 cycles.
4. Busy rejection:
   - Stimulus: second tx_start (cmd 8'h47) at cycle 500 of a frame.
   - Response: ignored; waveform unchanged; exactly one tx_done.
5. Carrier and reset:
   - During a mark, ir_out is 1,1,0,0,... from mark start; during spaces ir_out=0.
   - rst_n low at cycle 700 -> ir_out/ir_env 0 immediately, tx_ready=1, no tx_done.
6. NEC_EXT_ADDR_EN defined:
   - Stimulus: addr 16'h1234, cmd 8'h45.
   - Response: bytes 34, 12, 45, BA transmitted.
